// File: rtl/riscv_fetch.sv
// Instruction-fetch front end: owns the PC, issues word reads over req/gnt/rvalid
// and hands {pc, instr} pairs to decode through a single-entry output slot.
module riscv_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_fetch_count,
  output logic [1:0]  o_state
);

  // Handshakes: a memory request transfers when o_imem_req && i_imem_gnt; read
  // data is taken when i_imem_rvalid arrives in S_WAIT; decode takes the slot
  // when o_valid && i_ready. o_instr/o_pc stay stable while o_valid && !i_ready.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] opc_q, opc_d;
  logic [31:0] count_q, count_d;
  logic        handshake;
  logic        unused_redirect_bits;

  assign unused_redirect_bits = ^i_redirect_pc[1:0];

  assign handshake     = valid_q && i_ready;
  // A new fetch only starts when the slot is empty or draining this cycle,
  // so at most one instruction is ever in flight or parked in the slot.
  assign o_imem_req    = (state_q == S_REQ) && !i_rst && !i_redirect && (!valid_q || i_ready);
  assign o_imem_addr   = pc_q;
  assign o_valid       = valid_q;
  assign o_instr       = instr_q;
  assign o_pc          = opc_q;
  assign o_fetch_count = count_q;
  assign o_state       = state_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    opc_d    = opc_q;
    count_d  = count_q;

    if (i_redirect) begin
      pc_d    = {i_redirect_pc[31:2], 2'b00};
      valid_d = 1'b0;
      unique case (state_q)
        S_WAIT:  state_d = i_imem_rvalid ? S_REQ : S_DROP;
        S_DROP:  state_d = i_imem_rvalid ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
    end else begin
      if (handshake) begin
        valid_d = 1'b0;
        count_d = count_q + 32'd1;
      end
      unique case (state_q)
        S_REQ: begin
          if (o_imem_req && i_imem_gnt) begin
            pc_d     = pc_q + 32'd4;
            req_pc_d = pc_q;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_imem_rvalid) begin
            valid_d = 1'b1;
            instr_d = i_imem_rdata;
            opc_d   = req_pc_q;
            state_d = S_REQ;
          end
        end
        S_DROP: begin
          if (i_imem_rvalid) begin
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= 32'd0;
      opc_q    <= 32'd0;
      count_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      opc_q    <= opc_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_riscv_fetch.sv
// Directed bench for riscv_fetch: inputs change just after the falling edge,
// outputs are sampled 1 time unit later, well away from the rising edge.
module tb_riscv_fetch;

  logic        i_clk;
  logic        i_rst;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic [31:0] o_fetch_count;
  logic [1:0]  o_state;

  int checks;
  int errors;
  logic [31:0] exp_q[$];
  logic [31:0] exp_instr;

  riscv_fetch #(.RESET_PC(32'h0000_1000)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_gnt(i_imem_gnt), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_valid(o_valid), .i_ready(i_ready), .o_instr(o_instr), .o_pc(o_pc),
    .o_fetch_count(o_fetch_count), .o_state(o_state)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic step;
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic test_reset;
    i_rst = 1'b1; i_ready = 1'b1; i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0;
    i_imem_rdata = 32'd0; i_redirect = 1'b0; i_redirect_pc = 32'd0;
    @(negedge i_clk);
    #1;
    checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL rst_req_low got %0h exp 0", o_imem_req); end
    step;
    i_rst = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h exp 0", o_valid); end
    checks++; if (o_instr !== 32'd0) begin errors++; $display("FAIL rst_instr got %h exp 0", o_instr); end
    checks++; if (o_pc !== 32'd0) begin errors++; $display("FAIL rst_pc got %h exp 0", o_pc); end
    checks++; if (o_fetch_count !== 32'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", o_fetch_count); end
    checks++; if (o_imem_addr !== 32'h0000_1000) begin errors++; $display("FAIL rst_addr got %h exp 00001000", o_imem_addr); end
    checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", o_state); end
    checks++; if (o_imem_req !== 1'b1) begin errors++; $display("FAIL rst_req_after got %0h exp 1", o_imem_req); end
  endtask

  task automatic test_stream;
    for (int k = 0; k < 5; k++) begin
      i_imem_gnt = 1'b1; i_imem_rvalid = 1'b0; i_ready = 1'b1;
      #1;
      checks++; if (o_imem_req !== 1'b1) begin errors++; $display("FAIL stream_req[%0d] got %0h exp 1", k, o_imem_req); end
      checks++; if (o_imem_addr !== 32'h1000 + 32'(4 * k)) begin errors++; $display("FAIL stream_addr[%0d] got %h exp %h", k, o_imem_addr, 32'h1000 + 32'(4 * k)); end
      checks++; if (o_valid !== (k > 0)) begin errors++; $display("FAIL stream_valid[%0d] got %0h exp %0h", k, o_valid, (k > 0)); end
      checks++; if (o_fetch_count !== 32'((k == 0) ? 0 : k - 1)) begin errors++; $display("FAIL stream_count[%0d] got %0d exp %0d", k, o_fetch_count, (k == 0) ? 0 : k - 1); end
      if (k > 0) begin
        exp_instr = exp_q.pop_front();
        checks++; if (o_pc !== 32'h1000 + 32'(4 * (k - 1))) begin errors++; $display("FAIL stream_pc[%0d] got %h exp %h", k, o_pc, 32'h1000 + 32'(4 * (k - 1))); end
        checks++; if (o_instr !== exp_instr) begin errors++; $display("FAIL stream_instr[%0d] got %h exp %h", k, o_instr, exp_instr); end
      end
      step;
      i_imem_rvalid = 1'b1; i_imem_rdata = 32'h0010_0013 + 32'(k);
      exp_q.push_back(i_imem_rdata);
      #1;
      checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL stream_wait_req[%0d] got %0h exp 0", k, o_imem_req); end
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL stream_wait_valid[%0d] got %0h exp 0", k, o_valid); end
      checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL stream_wait_state[%0d] got %0d exp 1", k, o_state); end
      step;
    end
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0;
    exp_instr = exp_q.pop_front();
    #1;
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL stream_last_valid got %0h exp 1", o_valid); end
    checks++; if (o_pc !== 32'h0000_1010) begin errors++; $display("FAIL stream_last_pc got %h exp 00001010", o_pc); end
    checks++; if (o_instr !== exp_instr) begin errors++; $display("FAIL stream_last_instr got %h exp %h", o_instr, exp_instr); end
    checks++; if (o_fetch_count !== 32'd4) begin errors++; $display("FAIL stream_last_count got %0d exp 4", o_fetch_count); end
    step;
    #1;
    checks++; if (o_fetch_count !== 32'd5) begin errors++; $display("FAIL stream_count5 got %0d exp 5", o_fetch_count); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL stream_drained got %0h exp 0", o_valid); end
    checks++; if (o_imem_addr !== 32'h0000_1014) begin errors++; $display("FAIL stream_next_addr got %h exp 00001014", o_imem_addr); end
  endtask

  task automatic test_backpressure;
    i_imem_gnt = 1'b1; i_ready = 1'b1;
    step;
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'h0050_0093;
    step;
    i_imem_rvalid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      i_ready = 1'b0; i_imem_gnt = 1'b1;
      #1;
      checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %0h exp 1", j, o_valid); end
      checks++; if (o_pc !== 32'h0000_1014) begin errors++; $display("FAIL bp_pc[%0d] got %h exp 00001014", j, o_pc); end
      checks++; if (o_instr !== 32'h0050_0093) begin errors++; $display("FAIL bp_instr[%0d] got %h exp 00500093", j, o_instr); end
      checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL bp_req[%0d] got %0h exp 0", j, o_imem_req); end
      step;
    end
    i_ready = 1'b1;
    #1;
    checks++; if (o_imem_req !== 1'b1) begin errors++; $display("FAIL bp_release_req got %0h exp 1", o_imem_req); end
    checks++; if (o_imem_addr !== 32'h0000_1018) begin errors++; $display("FAIL bp_release_addr got %h exp 00001018", o_imem_addr); end
    checks++; if (o_fetch_count !== 32'd5) begin errors++; $display("FAIL bp_count_before got %0d exp 5", o_fetch_count); end
    step;
    i_imem_gnt = 1'b0;
    #1;
    checks++; if (o_fetch_count !== 32'd6) begin errors++; $display("FAIL bp_count_after got %0d exp 6", o_fetch_count); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %0h exp 0", o_valid); end
    checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL bp_state got %0d exp 1", o_state); end
  endtask

  task automatic test_redirect_wait;
    i_redirect = 1'b1; i_redirect_pc = 32'h0000_0100; i_imem_rvalid = 1'b0;
    #1;
    checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL rw_req got %0h exp 0", o_imem_req); end
    step;
    i_redirect = 1'b0;
    #1;
    checks++; if (o_state !== 2'd2) begin errors++; $display("FAIL rw_drop_state got %0d exp 2", o_state); end
    checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL rw_drop_req got %0h exp 0", o_imem_req); end
    step;
    i_imem_rvalid = 1'b1; i_imem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rw_valid_pre got %0h exp 0", o_valid); end
    step;
    i_imem_rvalid = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rw_dropped got %0h exp 0", o_valid); end
    checks++; if (o_imem_req !== 1'b1) begin errors++; $display("FAIL rw_next_req got %0h exp 1", o_imem_req); end
    checks++; if (o_imem_addr !== 32'h0000_0100) begin errors++; $display("FAIL rw_next_addr got %h exp 00000100", o_imem_addr); end
    checks++; if (o_fetch_count !== 32'd6) begin errors++; $display("FAIL rw_count got %0d exp 6", o_fetch_count); end
    checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL rw_state got %0d exp 0", o_state); end
  endtask

  task automatic test_redirect_rvalid;
    i_imem_gnt = 1'b1;
    step;
    i_imem_gnt = 1'b0; i_redirect = 1'b1; i_redirect_pc = 32'h0000_0203;
    i_imem_rvalid = 1'b1; i_imem_rdata = 32'h1111_1111;
    #1;
    checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL rr_req got %0h exp 0", o_imem_req); end
    step;
    i_redirect = 1'b0; i_imem_rvalid = 1'b0; i_imem_gnt = 1'b1;
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rr_valid got %0h exp 0", o_valid); end
    checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL rr_state got %0d exp 0", o_state); end
    checks++; if (o_imem_addr !== 32'h0000_0200) begin errors++; $display("FAIL rr_addr got %h exp 00000200", o_imem_addr); end
    checks++; if (o_imem_req !== 1'b1) begin errors++; $display("FAIL rr_next_req got %0h exp 1", o_imem_req); end
    step;
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'h2222_2222;
    step;
    i_imem_rvalid = 1'b0; i_ready = 1'b1; i_redirect = 1'b1; i_redirect_pc = 32'h0000_0300;
    #1;
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL rh_valid got %0h exp 1", o_valid); end
    checks++; if (o_pc !== 32'h0000_0200) begin errors++; $display("FAIL rh_pc got %h exp 00000200", o_pc); end
    checks++; if (o_instr !== 32'h2222_2222) begin errors++; $display("FAIL rh_instr got %h exp 22222222", o_instr); end
    checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL rh_req got %0h exp 0", o_imem_req); end
    step;
    i_redirect_pc = 32'h0000_0404;
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rh_flushed got %0h exp 0", o_valid); end
    checks++; if (o_fetch_count !== 32'd6) begin errors++; $display("FAIL rh_count got %0d exp 6", o_fetch_count); end
    step;
    i_redirect = 1'b0;
    #1;
    checks++; if (o_imem_addr !== 32'h0000_0404) begin errors++; $display("FAIL rb2b_addr got %h exp 00000404", o_imem_addr); end
    checks++; if (o_imem_req !== 1'b1) begin errors++; $display("FAIL rb2b_req got %0h exp 1", o_imem_req); end
    checks++; if (o_fetch_count !== 32'd6) begin errors++; $display("FAIL rb2b_count got %0d exp 6", o_fetch_count); end
  endtask

  task automatic test_mid_reset;
    i_imem_gnt = 1'b1;
    step;
    i_imem_gnt = 1'b0; i_rst = 1'b1;
    #1;
    checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL mr_req_in_rst got %0h exp 0", o_imem_req); end
    step;
    i_rst = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'h3333_3333;
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mr_valid got %0h exp 0", o_valid); end
    checks++; if (o_pc !== 32'd0) begin errors++; $display("FAIL mr_pc got %h exp 0", o_pc); end
    checks++; if (o_instr !== 32'd0) begin errors++; $display("FAIL mr_instr got %h exp 0", o_instr); end
    checks++; if (o_fetch_count !== 32'd0) begin errors++; $display("FAIL mr_count got %0d exp 0", o_fetch_count); end
    checks++; if (o_imem_addr !== 32'h0000_1000) begin errors++; $display("FAIL mr_addr got %h exp 00001000", o_imem_addr); end
    checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL mr_state got %0d exp 0", o_state); end
    checks++; if (o_imem_req !== 1'b1) begin errors++; $display("FAIL mr_req got %0h exp 1", o_imem_req); end
    step;
    i_imem_rvalid = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mr_stray_valid got %0h exp 0", o_valid); end
    checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL mr_stray_state got %0d exp 0", o_state); end
    checks++; if (o_imem_addr !== 32'h0000_1000) begin errors++; $display("FAIL mr_stray_addr got %h exp 00001000", o_imem_addr); end
  endtask

  task automatic test_count_wrap;
    i_imem_gnt = 1'b1; i_ready = 1'b1;
    step;
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'h4444_4444;
    step;
    i_imem_rvalid = 1'b0;
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    #1;
    checks++; if (o_fetch_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_pre got %h exp ffffffff", o_fetch_count); end
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got %0h exp 1", o_valid); end
    checks++; if (o_pc !== 32'h0000_1000) begin errors++; $display("FAIL wrap_pc got %h exp 00001000", o_pc); end
    checks++; if (o_instr !== 32'h4444_4444) begin errors++; $display("FAIL wrap_instr got %h exp 44444444", o_instr); end
    step;
    #1;
    checks++; if (o_fetch_count !== 32'd0) begin errors++; $display("FAIL wrap_post got %h exp 0", o_fetch_count); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL wrap_drained got %0h exp 0", o_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_stream;
    test_backpressure;
    test_redirect_wait;
    test_redirect_rvalid;
    test_mid_reset;
    test_count_wrap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_fetch.md
Name: riscv_fetch

Overview:
- Instruction-fetch front end for verilog_riscv. Sits directly upstream of the core's decode stage.
- Holds the PC and issues word reads to instruction memory over a req/gnt/rvalid interface.
- Delivers {pc, instruction} pairs to decode over a valid/ready handshake.
- Honours redirects (branches, jumps, traps) from execute by discarding stale in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- i_clk  input  1  clock, all state updates on rising edge
- i_rst  input  1  synchronous, active-high reset
- o_imem_req  output  1  fetch request valid
- o_imem_addr  output  32  word-aligned fetch address (= current PC)
- i_imem_gnt  input  1  memory accepts the request this cycle
- i_imem_rvalid  input  1  read data valid; earliest 1 cycle after gnt
- i_imem_rdata  input  32  instruction word
- i_redirect  input  1  redirect PC from execute
- i_redirect_pc  input  32  redirect target
- o_valid  output  1  instruction slot valid to decode
- i_ready  input  1  decode accepts slot this cycle
- o_instr  output  32  instruction word
- o_pc  output  32  PC of o_instr
- o_fetch_count  output  32  number of instructions handed to decode, wraps

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - pc=RESET_PC, state=S_REQ, o_valid=0, o_instr=0, o_pc=0, o_fetch_count=0.
  - o_imem_req is 0 while i_rst=1.
- Output slot: single entry.
  - A handshake occurs when o_valid && i_ready.
  - o_instr and o_pc are held stable while o_valid=1 and i_ready=0.
- Invariant: outstanding memory requests + slot occupancy <= 1.
- States:
  - S_REQ: o_imem_req = !i_rst && !i_redirect && (!o_valid || i_ready). o_imem_addr = pc.
    - On req && gnt: pc <= pc+4 (mod 2^32), go S_WAIT, latch req_pc = pc.
  - S_WAIT: o_imem_req=0.
    - On rvalid: o_valid <= 1, o_instr <= rdata, o_pc <= req_pc, go S_REQ.
  - S_DROP: o_imem_req=0.
    - On rvalid: data discarded, go S_REQ.
- Throughput: best case one instruction every 2 cycles (gnt cycle, then rvalid cycle). The next request may be issued in the same cycle as the handshake that drains the slot.
- Redirect (has priority over everything except reset):
  - pc <= {i_redirect_pc[31:2], 2'b00}; o_valid <= 0 (slot flushed, no handshake counted even if i_ready=1).
  - S_REQ: stay S_REQ. No request is issued in the redirect cycle, so gnt cannot coincide with it.
  - S_WAIT without rvalid: go S_DROP.
  - S_WAIT with rvalid the same cycle: data discarded, go S_REQ.
  - S_DROP without rvalid: pc updated, stay S_DROP. With rvalid: go S_REQ.
  - Back-to-back redirects: the last target wins.
- o_fetch_count increments by 1 on every handshake not coinciding with i_redirect. It wraps 32'hFFFF_FFFF -> 0.
- i_imem_gnt is ignored when o_imem_req=0. i_imem_rvalid is ignored in S_REQ.
- Reset mid-operation (any state, outstanding request):
  - Everything returns to reset values and the state returns to S_REQ.
  - A later rvalid for the abandoned request, arriving in S_REQ, is ignored.

Test Plan:
- Reset, memory with gnt=1 always and rvalid 1 cycle later, i_ready=1: addresses 0,4,8,... issued every 2 cycles; o_pc tracks them; after 5 handshakes o_fetch_count=5.
- Backpressure: i_ready=0 for 4 cycles with o_valid=1, pc 0x8, instr 0x00500093: slot held stable, o_imem_req=0; when i_ready=1, the next request to 0xC is issued in that same cycle.
- Redirect in S_WAIT (request to 0x10 outstanding), i_redirect_pc=0x100, rvalid 2 cycles later with 0xDEADBEEF: data dropped, o_valid never 1 for it, next request addr=0x100.
- Redirect coinciding with rvalid in S_WAIT and with a handshake in progress: slot flushed, count unchanged, next addr = target; misaligned target 0x203 yields addr 0x200.
- Mid-run reset with a request outstanding: outputs return to 0, next request addr=RESET_PC (test with RESET_PC=32'h0000_1000); a stray rvalid is ignored.
- Counter wrap: force o_fetch_count to 32'hFFFF_FFFF via 2^32 handshakes or backdoor; one handshake -> 0.
